stopwatch_ctrl: RTL
===================

// Module: stopwatch_ctrl
// PURPOSE
//   Run/pause/clear/lap controller for a 4-digit mm:ss BCD stopwatch. Derives a
//   seconds tick from clk, gates and cascades the enables of four bcd_digit
//   instances (s0 0-9, s1 0-5, m0 0-9, m1 0-5) and drives a display bus that
//   can be frozen for lap readout. Sits between the button one-pulse logic and
//   the 7-segment scanner.
// PARAMETERS
//   TICK_DIV  100_000_000  clk cycles per count tick; legal range >= 2
//   DIV_W     27           prescaler width; must satisfy 2**DIV_W >= TICK_DIV
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   reset, asynchronous, active-low
//   start_stop   in   1   single-cycle pulse; toggles run/pause
//   lap          in   1   single-cycle pulse; freezes or releases the display
//   clear        in   1   single-cycle pulse; stop and zero everything
//   count        out  16  live BCD value {m1,m0,s1,s0}
//   display      out  16  value for the scanner (live or frozen lap value)
//   running      out  1   1 while in RUN
//   lap_active   out  1   1 while display is frozen
//   wrap         out  1   1-cycle pulse when 59:59 rolls over to 00:00
// BEHAVIOUR
//   - Reset: state=IDLE, prescaler=0, count=16'h0000, display=16'h0000,
//     running=0, lap_active=0, wrap=0. All outputs are registered.
//   - FSM states: IDLE (stopped, zero), RUN, PAUSE.
//     IDLE  -start_stop-> RUN
//     RUN   -start_stop-> PAUSE
//     PAUSE -start_stop-> RUN
//     any   -clear-> IDLE (count, prescaler, lap_active zeroed next cycle)
//   - Priority for same-cycle pulses: clear > start_stop > lap. The lower
//     pulse is dropped.
//   - Prescaler: increments only in RUN, holds in PAUSE, zeroed in IDLE.
//     tick=1 in the cycle the prescaler == TICK_DIV-1 while in RUN; the
//     prescaler returns to 0 on that cycle.
//     First tick comes TICK_DIV cycles after entering RUN from IDLE.
//   - Cascade is combinational within one tick:
//       en_s0 = tick
//       en_s1 = tick & s0==9
//       en_m0 = en_s1 & s1==5
//       en_m1 = en_m0 & m0==9
//     Each enabled digit at its limit returns to 0.
//     count is updated the cycle after tick (1-cycle latency).
//   - wrap: asserted the cycle count changes 16'h5959 -> 16'h0000. The count
//     keeps running.
//   - Lap:
//     RUN, lap_active=0: latch count into display and set lap_active.
//     RUN or PAUSE, lap_active=1: release; display follows count again.
//     IDLE: lap is ignored.
//     While lap_active=0, display mirrors count in the same cycle (registered
//     copy of next count).
//   - start_stop arriving on a tick cycle: the tick is still applied, then the
//     state changes.
//   - Async reset mid-count: immediate return to reset values. There is no
//     partial-tick carry.
// CONFIGURATION
//   - LAP_FREEZE_EN defined: lap behaviour as above.
//   - LAP_FREEZE_EN undefined: lap port is present but ignored; lap_active is
//     tied to 0; display == count at all times.
// STRUCTURE
//   - Package stopwatch_pkg holds:
//     - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2
//     - digit limits LIM_S0=4'd9, LIM_S1=4'd5, LIM_M0=4'd9, LIM_M1=4'd5
//   - Sub-module bcd_digit (ports clk, rst_n, clr, en, limit[3:0], q[3:0],
//     at_lim) is instantiated 4x.
//   - The FSM, prescaler, cascade, lap latch and wrap detection stay in
//     stopwatch_ctrl.
// TESTING (TICK_DIV=4)
//   1. Reset, then start_stop: count=0001 five cycles after the pulse;
//      running=1; 0002 four cycles later.
//   2. Preload run to 0059, then one tick: count=0100. Then run to 5959 and
//      tick: count=0000, wrap high exactly 1 cycle.
//   3. Pause: start_stop at prescaler=2 in RUN, wait 20 cycles (count frozen),
//      then start_stop: next tick arrives 2 cycles after resume.
//   4. Lap: at count=0012 pulse lap: display stays 0012 while count advances
//      to 0015; pulse lap: display=0015 next cycle.
//   5. Same-cycle start_stop+clear in RUN: state IDLE, count=0000,
//      running=0. lap+clear: lap_active=0.
//   6. Assert rst_n low mid-prescale at count=0307: all outputs zero
//      asynchronously. With LAP_FREEZE_EN undefined, re-run 4: display==count
//      throughout.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings, digit limits and the BCD next-value helper for the
// mm:ss stopwatch.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_PAUSE = ST_PAUSE
    } state_e;

    localparam logic [3:0] LIM_S0 = 4'd9;
    localparam logic [3:0] LIM_S1 = 4'd5;
    localparam logic [3:0] LIM_M0 = 4'd9;
    localparam logic [3:0] LIM_M1 = 4'd5;

    // Next value of one BCD digit: clear wins, an enabled digit at its
    // limit rolls back to zero, otherwise it steps by one.
    function automatic logic [3:0] bcd_next(input logic [3:0] q,
                                            input logic [3:0] lim,
                                            input logic       en,
                                            input logic       clr);
        logic [3:0] r;
        r = q;
        if (clr)
            r = 4'd0;
        else if (en)
            r = (q == lim) ? 4'd0 : q + 4'd1;
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD counter digit with synchronous clear, enable and a configurable
// roll-over limit; at_lim flags the carry condition for the next digit.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] limit,
    output logic [3:0] q,
    output logic       at_lim
);

    logic [3:0] q_q, q_d;

    // Next-value selection shared with the display shadow in the top.
    always_comb begin
        q_d = bcd_next(q_q, limit, en, clr);
    end

    // Digit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= 4'd0;
        else
            q_q <= q_d;
    end

    assign q      = q_q;
    assign at_lim = (q_q == limit);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/lap controller for a 4-digit mm:ss BCD stopwatch.
// Optional feature macro: LAP_FREEZE_EN (lap freezes the display bus).
// Without it the lap input is ignored and display always equals count.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int DIV_W    = 27
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] count,
    output logic [15:0] display,
    output logic        running,
    output logic        lap_active,
    output logic        wrap
);

    // Digit order matches the count bus: index 3 is m1, index 0 is s0.
    localparam logic [3:0][3:0] LIMS = {LIM_M1, LIM_M0, LIM_S1, LIM_S0};

    state_e           st_q, st_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             tick;
    logic [3:0]       en;
    logic [3:0]       at_lim;
    logic [3:0][3:0]  dig;
    logic [15:0]      count_next;
    logic             running_q, wrap_q;

    assign tick = (st_q == S_RUN) && (presc_q == DIV_W'(TICK_DIV - 1));

    // Carry cascade resolves fully within the tick cycle.
    assign en[0] = tick;
    assign en[1] = en[0] & at_lim[0];
    assign en[2] = en[1] & at_lim[1];
    assign en[3] = en[2] & at_lim[2];

    for (genvar i = 0; i < 4; i++) begin : g_dig
        bcd_digit u_dig (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (clear),
            .en     (en[i]),
            .limit  (LIMS[i]),
            .q      (dig[i]),
            .at_lim (at_lim[i])
        );
    end

    assign count = dig;

    // Value the digits will hold next cycle, used for same-cycle display mirroring.
    always_comb begin
        count_next = '0;
        for (int i = 0; i < 4; i++)
            count_next[i*4 +: 4] = bcd_next(dig[i], LIMS[i], en[i], clear);
    end

    // Next state and prescaler; clear outranks start_stop, and a tick in the
    // same cycle as start_stop is still counted because the digits see it.
    always_comb begin
        st_d    = st_q;
        presc_d = presc_q;
        if (clear) begin
            st_d = S_IDLE;
        end else if (start_stop) begin
            case (st_q)
                S_IDLE:  st_d = S_RUN;
                S_RUN:   st_d = S_PAUSE;
                S_PAUSE: st_d = S_RUN;
                default: st_d = S_IDLE;
            endcase
        end
        case (st_q)
            S_RUN:   presc_d = tick ? '0 : presc_q + 1'b1;
            S_PAUSE: presc_d = presc_q;
            default: presc_d = '0;
        endcase
        if (clear)
            presc_d = '0;
    end

    // State, prescaler and status flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= S_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            presc_q   <= presc_d;
            running_q <= (st_d == S_RUN);
            wrap_q    <= tick && !clear && (dig == 16'h5959);
        end
    end

    assign running = running_q;
    assign wrap    = wrap_q;

`ifdef LAP_FREEZE_EN
    logic        lap_q, lap_d;
    logic [15:0] disp_q, disp_d;

    // Lap toggle: only RUN can freeze, RUN or PAUSE can release; a lap pulse
    // sharing a cycle with clear or start_stop is dropped.
    always_comb begin
        lap_d = lap_q;
        if (clear)
            lap_d = 1'b0;
        else if (lap && !start_stop) begin
            if (lap_q)
                lap_d = 1'b0;
            else if (st_q == S_RUN)
                lap_d = 1'b1;
        end
        disp_d = lap_d ? disp_q : count_next;
    end

    // Lap flag and display shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_q  <= 1'b0;
            disp_q <= 16'h0000;
        end else begin
            lap_q  <= lap_d;
            disp_q <= disp_d;
        end
    end

    assign display    = disp_q;
    assign lap_active = lap_q;
`else
    logic        unused_lap;
    logic [15:0] unused_next;
    assign unused_lap  = lap;
    assign unused_next = count_next;
    assign display     = count;
    assign lap_active  = 1'b0;
`endif

endmodule
